// File: rtl/afifo_rd_stream.sv
// Read-side adapter for the asynchronous FIFO: converts the request/empty port with
// 1-cycle RAM latency into a bubble-free valid/ready stream via a small skid buffer.
module afifo_rd_stream #(
  parameter int unsigned Width    = 8,
  parameter int unsigned BufDepth = 2,
  parameter int unsigned CntWidth = 16
) (
  input  logic                      RDclk,
  input  logic                      reset,
  input  logic                      FIFOempty,
  input  logic [Width-1:0]          RDdata,
  output logic                      RDreq,
  output logic [Width-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(BufDepth):0] occupancy,
  output logic [CntWidth-1:0]       words_out
);

  localparam int unsigned PtrW = $clog2(BufDepth);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned SumW = OccW + 1;

  if (BufDepth < 2 || (BufDepth & (BufDepth - 1)) != 0) begin : g_bad_depth
    $error("afifo_rd_stream: BufDepth must be a power of two >= 2");
  end

  logic [Width-1:0]    mem [BufDepth];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [OccW-1:0]     occ;
  logic                inflight;
  logic [CntWidth-1:0] cnt;

  logic                pop;
  logic [SumW-1:0]     demand;

  // Request is allowed to look at this cycle's pop so reads stay back-to-back.
  always_comb begin
    pop    = 1'b0;
    demand = '0;
    RDreq  = 1'b0;
    pop    = (occ != '0) & out_ready;
    demand = SumW'(occ) + SumW'(inflight) - SumW'(pop);
    RDreq  = ~FIFOempty & (demand < SumW'(BufDepth));
  end

  always_ff @(posedge RDclk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BufDepth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
    end else begin
      inflight <= RDreq;
      if (inflight) begin
        mem[wr_ptr] <= RDdata;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
        cnt    <= cnt + CntWidth'(1);
      end
      occ <= OccW'(demand);
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = (occ != '0);
  assign occupancy = occ;
  assign words_out = cnt;

  a_occ_max: assert property (@(posedge RDclk) disable iff (!reset)
    occ <= OccW'(BufDepth));
  a_occ_inflight: assert property (@(posedge RDclk) disable iff (!reset)
    (SumW'(occ) + SumW'(inflight)) <= SumW'(BufDepth));
  a_no_req_empty: assert property (@(posedge RDclk) disable iff (!reset)
    !(RDreq && FIFOempty));

endmodule
